// File: rtl/tile_pkg.sv
// Shared constants for the routing tile: channel width, configuration word
// layout and the switch-block routing codes.
package tile_pkg;

    localparam int CHAN_W = 3;

    // Configuration word layout, LSB offsets and widths of each block's field
    localparam int CLB_W  = 23;
    localparam int CB_W   = 18;
    localparam int SB_W   = 18;
    localparam int CFG_W  = CLB_W + 2 * CB_W + SB_W;

    localparam int CLB_LSB = 54;
    localparam int BL_LSB  = 36;
    localparam int TR_LSB  = 18;
    localparam int SB_LSB  = 0;

    // CLB field: 16-bit LUT, then register select and the two output enables
    localparam int LUT_W        = 16;
    localparam int CLB_REG_BIT  = 16;
    localparam int CLB_EN_H_BIT = 17;
    localparam int CLB_EN_V_BIT = 18;

    // Connection-block field: six one-hot track masks
    localparam int CB_CLB_SEL  = 15;
    localparam int CB_OUT_SEL  = 12;
    localparam int CB_DRV_CLB  = 9;
    localparam int CB_DRV_NBR  = 6;
    localparam int CB_DRV_SIDE = 3;
    localparam int CB_PASS     = 0;

    // Switch-block field: one 3-bit code per output, H outputs low, V high
    localparam int SB_CODE_W = 3;
    localparam int SB_V_OFS  = SB_CODE_W * CHAN_W;

    // Codes 5..7 are unassigned and leave the output floating like SB_OFF
    typedef enum logic [SB_CODE_W-1:0] {
        SB_OFF      = 3'd0,
        SB_STRAIGHT = 3'd1,
        SB_TURN_0   = 3'd2,
        SB_TURN_1   = 3'd3,
        SB_TURN_2   = 3'd4
    } sb_code_e;

endpackage

// File: rtl/tile_if.sv
// Configuration bus into the tile: a write strobe plus the full config word.
interface tile_if;
    import tile_pkg::*;

    logic             wr_en;
    logic [CFG_W-1:0] bits;

    modport master (output wr_en, output bits);
    modport slave  (input  wr_en, input  bits);
endinterface

// File: rtl/clb.sv
// Configurable logic block: a 4-input LUT with an optional output register
// and individually enabled tri-state outputs toward the up/left neighbours.
module clb
    import tile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [CLB_W-1:0] cfg,
    input  logic             up_i,
    input  logic             down_i,
    input  logic             right_i,
    input  logic             left_i,
    output logic             clb_o,
    output wire              lc_V_o,
    output wire              lc_H_o
);

    logic [3:0]       idx;
    logic [LUT_W-1:0] lut_bits;
    logic             lut_out;
    logic             ff_q;
    logic             unused_rsvd;

    assign idx      = {up_i, down_i, right_i, left_i};
    assign lut_bits = cfg[LUT_W-1:0];
    // The LUT is stored MSB-first: entry idx lives at bit 15-idx, i.e. ~idx.
    assign lut_out  = lut_bits[~idx];

    // Output register samples the LUT every cycle, whether or not it is selected
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff_q <= 1'b0;
        end else begin
            ff_q <= lut_out;
        end
    end

    assign clb_o  = cfg[CLB_REG_BIT] ? ff_q : lut_out;
    assign lc_V_o = cfg[CLB_EN_V_BIT] ? clb_o : 1'bz;
    assign lc_H_o = cfg[CLB_EN_H_BIT] ? clb_o : 1'bz;

    // Top four CLB config bits are reserved
    assign unused_rsvd = ^cfg[CLB_W-1:CLB_EN_V_BIT+1];

endmodule

// File: rtl/conn_block.sv
// Connection block: taps the channel into a CLB pin and a neighbour output,
// and optionally drives each track from the CLB, the neighbour CLB, the side
// input or the incoming track itself (in that priority order).
module conn_block
    import tile_pkg::*;
(
    input  logic [CB_W-1:0]   cfg,
    input  logic [CHAN_W-1:0] track_i,
    input  logic              lc_i,
    input  logic              side_i,
    input  logic              clb_o,
    output logic              pin,
    output logic              cl_o,
    output wire  [CHAN_W-1:0] track_o
);

    logic [CHAN_W-1:0] clb_sel;
    logic [CHAN_W-1:0] out_sel;
    logic [CHAN_W-1:0] drv_clb;
    logic [CHAN_W-1:0] drv_nbr;
    logic [CHAN_W-1:0] drv_side;
    logic [CHAN_W-1:0] pass;

    assign clb_sel  = cfg[CB_CLB_SEL  +: CHAN_W];
    assign out_sel  = cfg[CB_OUT_SEL  +: CHAN_W];
    assign drv_clb  = cfg[CB_DRV_CLB  +: CHAN_W];
    assign drv_nbr  = cfg[CB_DRV_NBR  +: CHAN_W];
    assign drv_side = cfg[CB_DRV_SIDE +: CHAN_W];
    assign pass     = cfg[CB_PASS     +: CHAN_W];

    // Unselected tracks are masked to 0, so a floating unused track cannot leak in
    assign pin  = |(track_i & clb_sel);
    assign cl_o = |(track_i & out_sel);

    for (genvar j = 0; j < CHAN_W; j++) begin : g_trk
        assign track_o[j] = drv_clb[j]  ? clb_o      :
                            drv_nbr[j]  ? lc_i       :
                            drv_side[j] ? side_i     :
                            pass[j]     ? track_i[j] : 1'bz;
    end

endmodule

// File: rtl/tile.sv
// Routing tile: config register, one CLB, bottom-left and top-right
// connection blocks and the switch block joining H and V channels.
module tile
    import tile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    tile_if.slave             cfg_bus,
    input  logic              cl_V_i,
    input  logic              cl_H_i,
    input  logic              lc_V_i,
    input  logic              lc_H_i,
    input  logic [CHAN_W-1:0] sc_H_i,
    input  logic [CHAN_W-1:0] sc_V_i,
    output wire               lc_V_o,
    output wire               lc_H_o,
    output logic              cl_V_o,
    output logic              cl_H_o,
    output wire  [CHAN_W-1:0] sc_H_o,
    output wire  [CHAN_W-1:0] sc_V_o
);

    logic [CFG_W-1:0]  cfg_q;
    logic              clb_o;
    logic              down_pin;
    logic              right_pin;
    wire  [CHAN_W-1:0] h_track;
    wire  [CHAN_W-1:0] v_track;

    // Config register; reset wins over a concurrent write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_q <= '0;
        end else if (cfg_bus.wr_en) begin
            cfg_q <= cfg_bus.bits;
        end
    end

    clb CLB0 (
        .clk     (clk),
        .reset   (reset),
        .cfg     (cfg_q[CLB_LSB +: CLB_W]),
        .up_i    (cl_V_i),
        .down_i  (down_pin),
        .right_i (right_pin),
        .left_i  (cl_H_i),
        .clb_o   (clb_o),
        .lc_V_o  (lc_V_o),
        .lc_H_o  (lc_H_o)
    );

    // Bottom-left block sits on the horizontal channel
    conn_block BL (
        .cfg     (cfg_q[BL_LSB +: CB_W]),
        .track_i (sc_H_i),
        .lc_i    (lc_V_i),
        .side_i  (cl_V_i),
        .clb_o   (clb_o),
        .pin     (down_pin),
        .cl_o    (cl_V_o),
        .track_o (h_track)
    );

    // Top-right block sits on the vertical channel
    conn_block TR (
        .cfg     (cfg_q[TR_LSB +: CB_W]),
        .track_i (sc_V_i),
        .lc_i    (lc_H_i),
        .side_i  (cl_H_i),
        .clb_o   (clb_o),
        .pin     (right_pin),
        .cl_o    (cl_H_o),
        .track_o (v_track)
    );

    // Switch block: each output picks its own channel straight or turns from
    // the other channel with a rotation; a floating source stays floating.
    for (genvar j = 0; j < CHAN_W; j++) begin : g_sb
        sb_code_e h_code;
        sb_code_e v_code;

        assign h_code = sb_code_e'(cfg_q[SB_LSB + SB_CODE_W*j +: SB_CODE_W]);
        assign v_code = sb_code_e'(cfg_q[SB_LSB + SB_V_OFS + SB_CODE_W*j +: SB_CODE_W]);

        assign sc_H_o[j] = (h_code == SB_STRAIGHT) ? h_track[j]                :
                           (h_code == SB_TURN_0)   ? v_track[j]                :
                           (h_code == SB_TURN_1)   ? v_track[(j+1) % CHAN_W]   :
                           (h_code == SB_TURN_2)   ? v_track[(j+2) % CHAN_W]   : 1'bz;

        assign sc_V_o[j] = (v_code == SB_STRAIGHT) ? v_track[j]                :
                           (v_code == SB_TURN_0)   ? h_track[j]                :
                           (v_code == SB_TURN_1)   ? h_track[(j+1) % CHAN_W]   :
                           (v_code == SB_TURN_2)   ? h_track[(j+2) % CHAN_W]   : 1'bz;
    end

endmodule

// File: tb/tb_tile.sv
// Bench for the routing tile: table of vectors per configuration plus
// hand-written reset, register-output and write-hold sequences.
module tb_tile;
    import tile_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cl_V_i, cl_H_i, lc_V_i, lc_H_i;
    logic [2:0] sc_H_i, sc_V_i;
    wire        lc_V_o, lc_H_o, cl_V_o, cl_H_o;
    wire  [2:0] sc_H_o, sc_V_o;

    tile_if cfg_bus ();

    tile dut (
        .clk     (clk),
        .reset   (reset),
        .cfg_bus (cfg_bus),
        .cl_V_i  (cl_V_i),
        .cl_H_i  (cl_H_i),
        .lc_V_i  (lc_V_i),
        .lc_H_i  (lc_H_i),
        .sc_H_i  (sc_H_i),
        .sc_V_i  (sc_V_i),
        .lc_V_o  (lc_V_o),
        .lc_H_o  (lc_H_o),
        .cl_V_o  (cl_V_o),
        .cl_H_o  (cl_H_o),
        .sc_H_o  (sc_H_o),
        .sc_V_o  (sc_V_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cl_v, cl_h, lc_v, lc_h;
        logic [2:0] sc_h, sc_v;
    } in_t;

    typedef struct packed {
        logic [2:0] sc_h, sc_v;
        logic       lc_v, lc_h, cl_v, cl_h;
    } out_t;

    typedef struct {
        int   phase;
        in_t  in;
        out_t exp;
    } vec_t;

    int   tests  = 0;
    int   failed = 0;
    out_t exp_q[$];
    string name_q[$];

    function automatic out_t rst_out();
        out_t o;
        o.sc_h = 3'bzzz; o.sc_v = 3'bzzz;
        o.lc_v = 1'bz;   o.lc_h = 1'bz;
        o.cl_v = 1'b0;   o.cl_h = 1'b0;
        return o;
    endfunction

    function automatic in_t rand_in();
        return in_t'($urandom_range(0, 1023));
    endfunction

    function automatic logic [CFG_W-1:0] cfg_word(logic [22:0] c, logic [17:0] bl,
                                                  logic [17:0] tr, logic [17:0] sb);
        return {c, bl, tr, sb};
    endfunction

    // Configurations exercised by the vector table
    function automatic logic [CFG_W-1:0] phase_cfg(int p);
        case (p)
            0: return cfg_word({4'b0, 3'b110, 16'b0001000100011111},
                               {3'b100, 3'b001, 3'b000, 3'b000, 3'b000, 3'b010},
                               {3'b100, 15'b0},
                               {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0});
            1: return cfg_word(23'b0,
                               18'b0,
                               {3'b000, 3'b010, 3'b000, 3'b001, 3'b010, 3'b100},
                               {3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0});
            2: return cfg_word({4'b0, 3'b100, 16'hFF00},
                               {15'b0, 3'b100},
                               {15'b0, 3'b111},
                               {3'd7, 3'd0, 3'd4, 3'd5, 3'd2, 3'd3});
            default: return cfg_word({4'b0, 3'b100, 16'hFF00},
                                     {15'b0, 3'b100},
                                     {6'b0, 3'b010, 6'b0, 3'b111},
                                     {3'd7, 3'd0, 3'd4, 3'd5, 3'd2, 3'd3});
        endcase
    endfunction

    // Expected outputs derived by hand from each configuration
    function automatic out_t model(int p, in_t i);
        out_t o;
        logic f;
        o = rst_out();
        case (p)
            0: begin
                f = (i.cl_v & i.sc_h[2]) | (i.sc_v[2] & i.cl_h);
                o.lc_v = f; o.lc_h = f;
                o.cl_v = i.sc_h[0];
                o.sc_h = {1'bz, i.sc_h[1], 1'bz};
            end
            1: begin
                o.cl_h = i.sc_v[1];
                o.sc_v = {i.sc_v[2], i.cl_h, i.lc_h};
            end
            2: begin
                o.lc_v = ~i.cl_v;
                o.sc_h = {1'bz, i.sc_v[1], i.sc_v[1]};
                o.sc_v = {2'bzz, i.sc_h[2]};
            end
            default: begin
                o.lc_v = ~i.cl_v;
                o.sc_h = {1'bz, ~i.cl_v, ~i.cl_v};
                o.sc_v = {2'bzz, i.sc_h[2]};
            end
        endcase
        return o;
    endfunction

    task automatic drive(input in_t i);
        cl_V_i = i.cl_v; cl_H_i = i.cl_h;
        lc_V_i = i.lc_v; lc_H_i = i.lc_h;
        sc_H_i = i.sc_h; sc_V_i = i.sc_v;
    endtask

    task automatic check_out();
        out_t  act;
        out_t  e;
        string n;
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL scoreboard_empty: no expected entry queued");
        end else begin
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            act = {sc_H_o, sc_V_o, lc_V_o, lc_H_o, cl_V_o, cl_H_o};
            if (act !== e) begin
                failed++;
                $display("FAIL %s: got %b want %b (sc_h,sc_v,lc_v,lc_h,cl_v,cl_h)", n, act, e);
            end
        end
    endtask

    // Drive after a falling edge, queue the expectation, compare mid low phase
    task automatic apply(input string n, input in_t i, input out_t e);
        @(negedge clk);
        drive(i);
        exp_q.push_back(e);
        name_q.push_back(n);
        #2 check_out();
    endtask

    task automatic check_now(input string n, input out_t e);
        exp_q.push_back(e);
        name_q.push_back(n);
        #1 check_out();
    endtask

    task automatic write_cfg(input logic [CFG_W-1:0] w);
        @(negedge clk);
        cfg_bus.bits  = w;
        cfg_bus.wr_en = 1'b1;
        @(posedge clk);
        #1 cfg_bus.wr_en = 1'b0;
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        in_t  i;
        out_t e;
        int   cur;

        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 20; k++) begin
                v.phase = p;
                v.in    = rand_in();
                v.exp   = model(p, v.in);
                vecs.push_back(v);
            end
        end

        reset         = 1'b1;
        cfg_bus.wr_en = 1'b0;
        cfg_bus.bits  = '0;
        drive(rand_in());

        // Reset held: random inputs and random writes must not disturb outputs
        for (int k = 0; k < 6; k++) begin
            apply("reset_hold", rand_in(), rst_out());
            cfg_bus.wr_en = 1'b1;
            cfg_bus.bits  = {$urandom, $urandom, $urandom};
        end
        cfg_bus.wr_en = 1'b0;
        reset         = 1'b0;
        apply("post_reset_0", rand_in(), rst_out());
        apply("post_reset_1", rand_in(), rst_out());

        cur = -1;
        foreach (vecs[n]) begin
            if (vecs[n].phase != cur) begin
                cur = vecs[n].phase;
                write_cfg(phase_cfg(cur));
            end
            apply($sformatf("vec_p%0d_%0d", vecs[n].phase, n), vecs[n].in, vecs[n].exp);
        end

        // New bits without a write strobe leave the configuration untouched
        @(negedge clk);
        cfg_bus.bits = {$urandom, $urandom, $urandom};
        repeat (3) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            i = rand_in();
            apply("hold_no_wr", i, model(3, i));
        end

        // Registered output: old value until the edge after the write, then new
        @(negedge clk);
        reset = 1'b1;
        #1 reset = 1'b0;
        write_cfg(cfg_word({4'b0, 3'b111, 16'hFFFF}, 18'b0, 18'b0, 18'b0));
        e = rst_out();
        e.lc_v = 1'b0; e.lc_h = 1'b0;
        apply("ff_before_edge", rand_in(), e);
        e.lc_v = 1'b1; e.lc_h = 1'b1;
        apply("ff_after_edge", rand_in(), e);
        apply("ff_hold", rand_in(), e);

        // Asynchronous reset takes effect without a clock edge
        @(negedge clk);
        #1 reset = 1'b1;
        check_now("reset_async", rst_out());
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Configuration is gone after reset until rewritten
        i = rand_in();
        apply("after_reset_discard", i, rst_out());
        write_cfg(phase_cfg(0));
        apply("rewrite_p0", i, model(0, i));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
